ex_muldiv_unit: RTL and testbench

- RV32M execute-stage unit. Sits directly downstream of the ID/EX pipeline register.
- Consumes its operand, func3 and rd outputs when the decoded instruction is an M-extension op (func7 = 0000001, R-type).
- Performs MUL/MULH/MULHSU/MULHU in a fixed 2-cycle sequence and DIV/DIVU/REM/REMU with an iterative 32-step restoring divider.
- Drives a stall back to the ID/EX write enable and the PC/IF-ID hold logic until the result is ready.

---
 rtl/riscv_m_pkg.sv | 23 ++
 rtl/div_iter_step.sv | 22 ++
 rtl/ex_muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_m_pkg.sv
// Shared encodings for the RV32M execute unit: func3 selects, M-extension func7
// and the multiply/divide sequencer states.
package riscv_m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNC7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift {rem, quo} left, subtract the divisor
// from the partial remainder when it fits and record the quotient bit.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] sh_rem;
  logic          fits;

  // The shifted remainder can reach XLEN+1 bits when the divisor has its MSB set.
  assign sh_rem = {rem_i, quo_i[XLEN-1]};
  assign fits   = sh_rem >= {1'b0, divisor_i};
  assign rem_o  = fits ? (sh_rem[XLEN-1:0] - divisor_i) : sh_rem[XLEN-1:0];
  assign quo_o  = {quo_i[XLEN-2:0], fits};

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: 2-cycle multiply, 32-step restoring divide, stall to ID/EX.
// state | meaning: IDLE wait for M-op | MUL product | DIV iterating | DONE result valid
module ex_muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_in_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_out_o
);

  localparam int CW = $clog2(XLEN);

  state_e            state_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q, b_q, rem_q, quo_q, dvs_q, result_q;
  logic [4:0]        rd_q, rd_out_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q_q, neg_r_q, done_q;

  logic              div_signed, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0]   abs_a, abs_b, special_res;
  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   rem_n, quo_n, div_res;

  assign div_signed  = ~func3_i[0];
  assign a_neg       = div_signed & op_a_i[XLEN-1];
  assign b_neg       = div_signed & op_b_i[XLEN-1];
  assign abs_a       = a_neg ? -op_a_i : op_a_i;
  assign abs_b       = b_neg ? -op_b_i : op_b_i;
  assign b_zero      = (op_b_i == '0);
  assign ovf         = div_signed & (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == '1);
  assign special_res = b_zero ? (func3_i[1] ? op_a_i : '1) : (func3_i[1] ? '0 : op_a_i);

  // Sign-extending to 2*XLEN keeps the low 2*XLEN bits of the product exact.
  assign mul_sa = a_q[XLEN-1] & ((f3_q == F3_MULH) | (f3_q == F3_MULHSU));
  assign mul_sb = b_q[XLEN-1] & (f3_q == F3_MULH);
  assign mul_a  = {{XLEN{mul_sa}}, a_q};
  assign mul_b  = {{XLEN{mul_sb}}, b_q};
  assign prod   = mul_a * mul_b;

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_n),
    .quo_o     (quo_n)
  );

  assign div_res = f3_q[1] ? (neg_r_q ? -rem_n : rem_n) : (neg_q_q ? -quo_n : quo_n);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else if (kill_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            f3_q <= func3_i;
            a_q  <= op_a_i;
            b_q  <= op_b_i;
            rd_q <= rd_in_i;
            if (!func3_i[2]) begin
              state_q <= ST_MUL;
            end else if (b_zero || ovf) begin
              result_q <= special_res;
              rd_out_q <= rd_in_i;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= abs_a;
              dvs_q   <= abs_b;
              cnt_q   <= '0;
              neg_q_q <= a_neg ^ b_neg;
              neg_r_q <= a_neg;
              state_q <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          result_q <= (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          rd_out_q <= rd_q;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DIV: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            result_q <= div_res;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall_o  = (start_i & (state_q == ST_IDLE) & ~kill_i) |
                    (state_q == ST_MUL) | (state_q == ST_DIV);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign rd_out_o = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: results, latency and stall per op class,
// divide corner cases, back-to-back issue, kill and mid-operation reset.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, kill;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int passes = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .kill_i   (kill),
    .func3_i  (func3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .rd_in_i  (rd_in),
    .stall_o  (stall),
    .done_o   (done),
    .result_o (result),
    .rd_out_o (rd_out)
  );

  always #5 clk = ~clk;

  // Issues one op for a single cycle, then scrambles operands; returns the cycle
  // count to done, the result/rd at done, stall cycles seen and stall at done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic [4:0] rdo, output int stall_cnt, output logic done_stall);
    bit seen = 0;
    @(posedge clk); #1;
    start = 1'b1; func3 = f3; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    stall_cnt = int'(stall);
    lat = 0; res = 'x; rdo = 'x; done_stall = 1'bx;
    while (!seen && lat < 60) begin
      @(posedge clk); #1;
      start = 1'b0; op_a = 32'h5A5A_1234; op_b = 32'h0F0F_0F0F; rd_in = 5'd31;
      lat++;
      @(negedge clk);
      if (done) begin
        seen = 1; res = result; rdo = rd_out; done_stall = stall;
      end else begin
        stall_cnt += int'(stall);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; func3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    #12;
    checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else passes++;
    checks++; if (rd_out !== 5'd0) $display("FAIL reset_rd: got %0d want 0", rd_out); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passes++;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [2:0]  f3  [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] va  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vb  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat, sc; logic [31:0] res; logic [4:0] rdo; logic ds;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], va[i], vb[i], 5'(i + 1), lat, res, rdo, sc, ds);
      checks++; if (res !== exp[i]) $display("FAIL mul%0d_result: got %h want %h", i, res, exp[i]); else passes++;
      checks++; if (lat != 2) $display("FAIL mul%0d_latency: got %0d want 2", i, lat); else passes++;
      checks++; if (sc != 2) $display("FAIL mul%0d_stall_cycles: got %0d want 2", i, sc); else passes++;
      checks++; if (ds !== 1'b0) $display("FAIL mul%0d_stall_at_done: got %b want 0", i, ds); else passes++;
      checks++; if (rdo !== 5'(i + 1)) $display("FAIL mul%0d_rd: got %0d want %0d", i, rdo, i + 1); else passes++;
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] va  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] vb  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int lat, sc; logic [31:0] res; logic [4:0] rdo; logic ds;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], va[i], vb[i], 5'(i + 10), lat, res, rdo, sc, ds);
      checks++; if (res !== exp[i]) $display("FAIL div%0d_result: got %h want %h", i, res, exp[i]); else passes++;
      checks++; if (lat != 33) $display("FAIL div%0d_latency: got %0d want 33", i, lat); else passes++;
      checks++; if (sc != 33) $display("FAIL div%0d_stall_cycles: got %0d want 33", i, sc); else passes++;
      checks++; if (rdo !== 5'(i + 10)) $display("FAIL div%0d_rd: got %0d want %0d", i, rdo, i + 10); else passes++;
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  f3  [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] va  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat, sc; logic [31:0] res; logic [4:0] rdo; logic ds;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], va[i], vb[i], 5'(i + 20), lat, res, rdo, sc, ds);
      checks++; if (res !== exp[i]) $display("FAIL special%0d_result: got %h want %h", i, res, exp[i]); else passes++;
      checks++; if (lat != 1) $display("FAIL special%0d_latency: got %0d want 1", i, lat); else passes++;
      checks++; if (rdo !== 5'(i + 20)) $display("FAIL special%0d_rd: got %0d want %0d", i, rdo, i + 20); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(posedge clk); #1;
    start = 1'b1; func3 = 3'b000; op_a = 32'd2; op_b = 32'd3; rd_in = 5'd3;
    @(negedge clk);
    while (!done && n < 10) begin @(negedge clk); n++; end
    checks++; if (result !== 32'd6) $display("FAIL b2b_first_result: got %h want 6", result); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL b2b_stall_at_done: got %b want 0", stall); else passes++;
    @(posedge clk); #1;
    op_a = 32'd5; op_b = 32'd6; rd_in = 5'd4;
    @(negedge clk);
    checks++; if (stall !== 1'b1) $display("FAIL b2b_second_stall: got %b want 1", stall); else passes++;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (done !== 1'b1) $display("FAIL b2b_second_done: got %b want 1", done); else passes++;
    checks++; if (result !== 32'd30) $display("FAIL b2b_second_result: got %h want 1e", result); else passes++;
    checks++; if (rd_out !== 5'd4) $display("FAIL b2b_second_rd: got %0d want 4", rd_out); else passes++;
  endtask

  task automatic test_kill();
    int lat, sc; logic [31:0] res; logic [4:0] rdo; logic ds; bit saw_done = 0;
    run_op(3'b000, 32'd3, 32'd5, 5'd7, lat, res, rdo, sc, ds);
    checks++; if (res !== 32'd15) $display("FAIL kill_pre_result: got %h want f", res); else passes++;
    @(posedge clk); #1;
    start = 1'b1; func3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; kill = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b1) $display("FAIL kill_stall_before: got %b want 1", stall); else passes++;
    @(posedge clk); #1; kill = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0) $display("FAIL kill_stall_after: got %b want 0", stall); else passes++;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    checks++; if (saw_done) $display("FAIL kill_no_done: got done pulse want none"); else passes++;
    checks++; if (result !== 32'd15) $display("FAIL kill_result_held: got %h want f", result); else passes++;
    checks++; if (rd_out !== 5'd7) $display("FAIL kill_rd_held: got %0d want 7", rd_out); else passes++;
  endtask

  task automatic test_reset_mid_op();
    int lat, sc; logic [31:0] res; logic [4:0] rdo; logic ds;
    @(posedge clk); #1;
    start = 1'b1; func3 = 3'b100; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd12;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    checks++; if (result !== 32'h0) $display("FAIL midrst_result: got %h want 0", result); else passes++;
    checks++; if (rd_out !== 5'd0) $display("FAIL midrst_rd: got %0d want 0", rd_out); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL midrst_stall: got %b want 0", stall); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else passes++;
    @(posedge clk); #1; rst_n = 1'b1;
    run_op(3'b000, 32'd3, 32'd4, 5'd2, lat, res, rdo, sc, ds);
    checks++; if (res !== 32'd12) $display("FAIL midrst_mul_result: got %h want c", res); else passes++;
    checks++; if (lat != 2) $display("FAIL midrst_mul_latency: got %0d want 2", lat); else passes++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_back_to_back();
    test_kill();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
